// File: rtl/bcd_digit_sequencer.sv
// rtl/bcd_digit_sequencer.sv - prescaled up/down BCD digit sequencer with load, step/carry/load_err strobes
// Optional FIB_DWELL_EN: adds fib input; Fibonacci digits dwell one extra prescaler period.
module bcd_digit_sequencer #(
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       up_down,
    input  logic       load,
    input  logic [3:0] load_val,
`ifdef FIB_DWELL_EN
    input  logic       fib,
`endif
    output logic [3:0] BCD_out,
    output logic       step,
    output logic       carry,
    output logic       load_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       digit_q, digit_d;
    logic             step_q, step_d;
    logic             carry_q, carry_d;
    logic             load_err_q, load_err_d;
    logic             dwell_hold;

`ifdef FIB_DWELL_EN
    logic             dwell_q, dwell_d;

    // A Fibonacci digit swallows its first terminal count, then steps on the second.
    assign dwell_hold = fib & ~dwell_q;
`else
    assign dwell_hold = 1'b0;
`endif

    always_comb begin
        cnt_d      = cnt_q;
        digit_d    = digit_q;
        step_d     = 1'b0;
        carry_d    = 1'b0;
        load_err_d = 1'b0;
`ifdef FIB_DWELL_EN
        dwell_d    = dwell_q;
`endif
        if (load) begin
            // Load wins over a coincident step edge; out-of-range values park at 0.
            cnt_d = '0;
`ifdef FIB_DWELL_EN
            dwell_d = 1'b0;
`endif
            if (load_val > 4'd9) begin
                digit_d    = 4'd0;
                load_err_d = 1'b1;
            end else begin
                digit_d = load_val;
            end
        end else if (enable) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (dwell_hold) begin
`ifdef FIB_DWELL_EN
                    dwell_d = 1'b1;
`endif
                end else begin
`ifdef FIB_DWELL_EN
                    dwell_d = 1'b0;
`endif
                    step_d = 1'b1;
                    if (up_down) begin
                        carry_d = (digit_q == 4'd9);
                        digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
                    end else begin
                        carry_d = (digit_q == 4'd0);
                        digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
                    end
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            digit_q    <= 4'd0;
            step_q     <= 1'b0;
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
`ifdef FIB_DWELL_EN
            dwell_q    <= 1'b0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            digit_q    <= digit_d;
            step_q     <= step_d;
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
`ifdef FIB_DWELL_EN
            dwell_q    <= dwell_d;
`endif
        end
    end

    assign BCD_out  = digit_q;
    assign step     = step_q;
    assign carry    = carry_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_digit_sequencer.sv
// tb/tb_bcd_digit_sequencer.sv - scoreboard bench for bcd_digit_sequencer (FIB_DWELL_EN adds the dwell test)
module tb_bcd_digit_sequencer;

`ifdef FIB_DWELL_EN
    localparam int D = 2;
`else
    localparam int D = 3;
`endif

    typedef struct {
        logic [3:0] digit;
        logic       st;
        logic       cy;
        logic       er;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       up_down;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] BCD_out;
    logic       step;
    logic       carry;
    logic       load_err;
    logic       fib_on;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

`ifdef FIB_DWELL_EN
    logic fib;
    assign fib = fib_on && (BCD_out inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8});
`endif

    bcd_digit_sequencer #(.TICK_DIV(D), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .up_down  (up_down),
        .load     (load),
        .load_val (load_val),
`ifdef FIB_DWELL_EN
        .fib      (fib),
`endif
        .BCD_out  (BCD_out),
        .step     (step),
        .carry    (carry),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int digit, input logic st, input logic cy, input logic er, input int c);
        exp_t e;
        e.digit = 4'(digit);
        e.st    = st;
        e.cy    = cy;
        e.er    = er;
        e.cyc   = c;
        sb.push_back(e);
    endtask

    // Monitor: every strobe must match the next scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        chk("bcd_range", int'(BCD_out <= 4'd9), 1);
        if (rst_n && (step || load_err)) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_strobe: got step=%0b carry=%0b load_err=%0b digit=%0d expected none (cycle %0d)",
                         step, carry, load_err, BCD_out, cyc);
            end else begin
                e = sb.pop_front();
                chk("sb_digit", BCD_out, e.digit);
                chk("sb_step", step, e.st);
                chk("sb_carry", carry, e.cy);
                chk("sb_load_err", load_err, e.er);
                chk("sb_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic drain(input string name);
        @(negedge clk);
        chk(name, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int base;
`ifdef FIB_DWELL_EN
        int dur[10] = '{4, 4, 4, 4, 2, 4, 2, 2, 4, 2};
`endif
        rst_n = 1'b0; enable = 1'b0; up_down = 1'b1;
        load = 1'b0; load_val = 4'd0; fib_on = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_bcd", BCD_out, 0);
        chk("reset_step", step, 0);
        chk("reset_carry", carry, 0);
        chk("reset_load_err", load_err, 0);

        // Up count from reset through the 9->0 wrap.
        base = cyc;
        for (int k = 1; k <= 10; k++) push(k % 10, 1'b1, k == 10, 1'b0, base + D * k);
        rst_n = 1'b1; enable = 1'b1; up_down = 1'b1;
        repeat (10 * D) @(negedge clk);
        enable = 1'b0;
        drain("t1_drain");
        chk("t1_final_bcd", BCD_out, 0);

        // Down count from a load of 2 through 0->9.
        load = 1'b1; load_val = 4'd2; up_down = 1'b0;
        @(negedge clk);
        chk("t2_load_bcd", BCD_out, 2);
        chk("t2_load_err", load_err, 0);
        load = 1'b0; enable = 1'b1;
        base = cyc;
        push(1, 1'b1, 1'b0, 1'b0, base + D);
        push(0, 1'b1, 1'b0, 1'b0, base + 2 * D);
        push(9, 1'b1, 1'b1, 1'b0, base + 3 * D);
        push(8, 1'b1, 1'b0, 1'b0, base + 4 * D);
        repeat (4 * D) @(negedge clk);
        enable = 1'b0;
        drain("t2_drain");

        // Illegal then legal load value.
        load = 1'b1; load_val = 4'b1110;
        push(0, 1'b0, 1'b0, 1'b1, cyc + 1);
        @(negedge clk);
        chk("t3_bad_bcd", BCD_out, 0);
        load_val = 4'b0110;
        @(negedge clk);
        chk("t3_good_bcd", BCD_out, 6);
        chk("t3_good_err", load_err, 0);
        load = 1'b0;
        drain("t3_drain");

        // Pause one count short of a step, resume.
        up_down = 1'b1; enable = 1'b1;
        repeat (D - 1) @(negedge clk);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        chk("t4_frozen_bcd", BCD_out, 6);
        push(7, 1'b1, 1'b0, 1'b0, cyc + 1);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        drain("t4_drain");
        chk("t4_final_bcd", BCD_out, 7);

        // Load coincident with a 9->0 step edge: load wins, no strobes.
        load = 1'b1; load_val = 4'd9;
        @(negedge clk);
        load = 1'b0; enable = 1'b1;
        repeat (D - 1) @(negedge clk);
        load = 1'b1; load_val = 4'd3;
        @(negedge clk);
        chk("t5_load_wins_bcd", BCD_out, 3);
        chk("t5_load_wins_step", step, 0);
        chk("t5_load_wins_carry", carry, 0);
        load = 1'b0;
        base = cyc;
        push(4, 1'b1, 1'b0, 1'b0, base + D);
        push(5, 1'b1, 1'b0, 1'b0, base + 2 * D);
        repeat (2 * D) @(negedge clk);

        // Asynchronous reset pulse between edges mid-count.
        @(negedge clk);
        push(1, 1'b1, 1'b0, 1'b0, cyc + D);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_bcd", BCD_out, 0);
        chk("t5_async_step", step, 0);
        #1 rst_n = 1'b1;
        repeat (D) @(negedge clk);
        enable = 1'b0;
        drain("t5_drain");

`ifdef FIB_DWELL_EN
        // Fibonacci digits last two prescaler periods.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; enable = 1'b1; up_down = 1'b1; fib_on = 1'b1;
        base = cyc;
        for (int d = 0; d < 10; d++) begin
            base += dur[d];
            push((d + 1) % 10, 1'b1, d == 9, 1'b0, base);
        end
        repeat (32) @(negedge clk);
        enable = 1'b0;
        drain("t6_drain");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
